// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: cell and winner codes, FSM states and the line table.
// The move validator uses the same LINES table, so keep the row/column/diagonal order stable.
package tictactoe_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    CELL_EMPTY   = 2'd0,
    CELL_X       = 2'd1,
    CELL_O       = 2'd2,
    CELL_INVALID = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_X    = 2'd1,
    WIN_O    = 2'd2
  } win_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_EVAL,
    ST_DONE
  } state_t;

  // Rows, then columns, then the two diagonals (row-major cell numbering).
  localparam logic [3:0] LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/line_eval.sv
// Combinational evaluation of all 8 lines over the 9 decoded cells.
// Zero latency; no flow control.
module line_eval
  import tictactoe_pkg::*;
(
  input  logic [2*NUM_CELLS-1:0] cells,
  output logic                   x_line,
  output logic                   o_line,
  output logic                   any_empty,
  output logic                   any_invalid,
  output logic [NUM_CELLS-1:0]   win_mask
);

  logic [1:0] c0, c1, c2;

  always_comb begin
    x_line      = 1'b0;
    o_line      = 1'b0;
    any_empty   = 1'b0;
    any_invalid = 1'b0;
    win_mask    = '0;
    c0          = CELL_EMPTY;
    c1          = CELL_EMPTY;
    c2          = CELL_EMPTY;

    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cells[2*i +: 2] == CELL_EMPTY)   any_empty   = 1'b1;
      if (cells[2*i +: 2] == CELL_INVALID) any_invalid = 1'b1;
    end

    for (int l = 0; l < NUM_LINES; l++) begin
      c0 = cells[2*LINES[l][0] +: 2];
      c1 = cells[2*LINES[l][1] +: 2];
      c2 = cells[2*LINES[l][2] +: 2];
      if (c0 == CELL_X && c1 == CELL_X && c2 == CELL_X) x_line = 1'b1;
      if (c0 == CELL_O && c1 == CELL_O && c2 == CELL_O) o_line = 1'b1;
      // A line owned by either player contributes; error masking is done by the caller.
      if ((c0 == CELL_X || c0 == CELL_O) && c0 == c1 && c1 == c2) begin
        win_mask[LINES[l][0]] = 1'b1;
        win_mask[LINES[l][1]] = 1'b1;
        win_mask[LINES[l][2]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/win_checker.sv
// Reads the 9 board cells through the RAM's registered port and reports winner/draw/error;
// 19 cycles start-to-done, +1 per ram_we stall in READ. Optional win_mask output: WIN_CHECKER_WIN_MASK_EN.
module win_checker
  import tictactoe_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         CELL_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              ram_we,
  output logic [7:0]        read_address,
  input  logic [CELL_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic              draw,
  output logic              error
`ifdef WIN_CHECKER_WIN_MASK_EN
  ,
  output logic [NUM_CELLS-1:0] win_mask
`endif
);

  state_t                 state;
  logic [3:0]             idx;
  logic [2*NUM_CELLS-1:0] cells;

  logic                 x_line, o_line, any_empty, any_invalid;
  logic [NUM_CELLS-1:0] line_mask;
  logic                 eval_err;

  function automatic logic [1:0] decode_cell(input logic [CELL_W-1:0] w);
    if (w == CELL_W'(0))      return CELL_EMPTY;
    else if (w == CELL_W'(1)) return CELL_X;
    else if (w == CELL_W'(2)) return CELL_O;
    else                      return CELL_INVALID;
  endfunction

  // Wraps modulo 256 by construction.
  function automatic logic [7:0] cell_addr(input logic [3:0] i);
    return BASE_ADDR + {4'd0, i};
  endfunction

  line_eval u_line_eval (
    .cells       (cells),
    .x_line      (x_line),
    .o_line      (o_line),
    .any_empty   (any_empty),
    .any_invalid (any_invalid),
    .win_mask    (line_mask)
  );

  assign eval_err = any_invalid | (x_line & o_line);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      read_address <= BASE_ADDR;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= WIN_NONE;
      draw         <= 1'b0;
      error        <= 1'b0;
      cells        <= '0;
`ifdef WIN_CHECKER_WIN_MASK_EN
      win_mask     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_READ;
            idx          <= '0;
            read_address <= cell_addr(4'd0);
            busy         <= 1'b1;
          end
        end
        // ram_we high means the RAM did not load d_out this edge: retry.
        ST_READ: begin
          if (!ram_we) state <= ST_CAPT;
        end
        ST_CAPT: begin
          cells[2*idx +: 2] <= decode_cell(ram_dout);
          if (idx == 4'(NUM_CELLS - 1)) begin
            state <= ST_EVAL;
          end else begin
            idx          <= idx + 4'd1;
            read_address <= cell_addr(idx + 4'd1);
            state        <= ST_READ;
          end
        end
        ST_EVAL: begin
          error <= eval_err;
          if (eval_err)    winner <= WIN_NONE;
          else if (x_line) winner <= WIN_X;
          else if (o_line) winner <= WIN_O;
          else             winner <= WIN_NONE;
          draw  <= !eval_err && !(|line_mask) && !any_empty;
`ifdef WIN_CHECKER_WIN_MASK_EN
          win_mask <= eval_err ? '0 : line_mask;
`endif
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy         <= 1'b0;
          read_address <= BASE_ADDR;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_win_checker.sv
// Bench for win_checker: directed boards, stalls, reset abort and random boards vs a line-table model.
module tb_win_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        ram_we;
  logic [7:0]  read_address;
  logic [15:0] ram_dout = '0;
  logic        busy, done, draw, error;
  logic [1:0]  winner;
`ifdef WIN_CHECKER_WIN_MASK_EN
  logic [8:0]  win_mask;
`endif

  logic [15:0] mem [256];
  logic [15:0] board [9];
  int vectors = 0;
  int miscompares = 0;

  win_checker #(.BASE_ADDR(8'h00), .CELL_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .ram_we       (ram_we),
    .read_address (read_address),
    .ram_dout     (ram_dout),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .draw         (draw),
    .error        (error)
`ifdef WIN_CHECKER_WIN_MASK_EN
    ,
    .win_mask     (win_mask)
`endif
  );

  always #5 clock = ~clock;

  // RAM with registered read port; write_enable blocks the d_out update.
  always @(posedge clock) if (!ram_we) ram_dout <= mem[read_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Straight from the game rules: enumerate rows, columns, diagonals and count marks.
  task automatic ref_model(output logic [1:0] w, output logic d, output logic e, output logic [8:0] m);
    int t [3];
    int nx, no;
    bit inv, emp, xw, ow;
    inv = 0; emp = 0; xw = 0; ow = 0; m = '0;
    for (int i = 0; i < 9; i++) begin
      if (board[i] == 16'd0) emp = 1;
      else if (board[i] > 16'd2) inv = 1;
    end
    for (int l = 0; l < 8; l++) begin
      if (l < 3)       t = '{3*l, 3*l+1, 3*l+2};
      else if (l < 6)  t = '{l-3, l, l+3};
      else if (l == 6) t = '{0, 4, 8};
      else             t = '{2, 4, 6};
      nx = 0; no = 0;
      for (int k = 0; k < 3; k++) begin
        if (board[t[k]] == 16'd1) nx++;
        if (board[t[k]] == 16'd2) no++;
      end
      if (nx == 3) xw = 1;
      if (no == 3) ow = 1;
      if (nx == 3 || no == 3)
        for (int k = 0; k < 3; k++) m[t[k]] = 1'b1;
    end
    e = inv | (xw & ow);
    w = e ? 2'b00 : xw ? 2'b01 : ow ? 2'b10 : 2'b00;
    d = !e && !xw && !ow && !emp;
    if (e || (!xw && !ow)) m = '0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 9; i++) mem[i] = board[i];
  endtask

  // Cycle index a no-stall run would be at, given stalls of n cycles on cell k.
  function automatic int phase(input int e, input int k, input int n);
    if (e < 2*k) return e;
    else if (e < 2*k + n) return 2*k;
    else return e - n;
  endfunction

  // Called #1 after a clock edge with the DUT idle.
  task automatic run_check(input int k, input int n, input bit poke_busy, input bit poke_done);
    logic [1:0] ew;
    logic ed, ee;
    logic [8:0] em;
    int lat, e, p;
    bit addr_ok;
    load_mem();
    ref_model(ew, ed, ee, em);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    e = 0; lat = -1; addr_ok = 1;
    ram_we = (e >= 2*k && e < 2*k + n);
    while (lat < 0 && e < 200) begin
      p = phase(e, k, n);
      if (p % 2 == 0 && p <= 16 && read_address !== 8'(p / 2)) addr_ok = 0;
      @(posedge clock); #1;
      e++;
      ram_we = (e >= 2*k && e < 2*k + n);
      if (poke_busy) start = (e == 5);
      if (done) lat = e;
    end
    chk("latency", lat, 19 + n);
    chk("read_addr_seq", addr_ok, 1);
    chk("winner", winner, ew);
    chk("draw", draw, ed);
    chk("error", error, ee);
`ifdef WIN_CHECKER_WIN_MASK_EN
    chk("win_mask", win_mask, em);
`endif
    ram_we = 1'b0;
    if (poke_done) start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("idle_after_done", busy, 0);
    chk("done_single_pulse", done, 0);
    chk("winner_held", winner, ew);
    if (poke_busy || poke_done) begin
      @(posedge clock); #1;
      chk("start_ignored", busy, 0);
    end
  endtask

  initial begin
    int r, dn;
    reset = 1'b1; start = 1'b0; ram_we = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_winner", winner, 0);
    chk("rst_draw", draw, 0);
    chk("rst_error", error, 0);
    chk("rst_addr", read_address, 8'h00);
`ifdef WIN_CHECKER_WIN_MASK_EN
    chk("rst_mask", win_mask, 0);
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    board = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0};
    run_check(0, 0, 0, 0);
    board = '{16'd1, 16'd1, 16'd2, 16'd1, 16'd2, 16'd0, 16'd2, 16'd0, 16'd0};
    run_check(0, 0, 1, 0);
    board = '{16'd1, 16'd2, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd1, 16'd1};
    run_check(0, 0, 0, 1);
    board = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0};
    run_check(0, 0, 0, 0);
    board = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd0, 16'd0, 16'd0};
    run_check(0, 0, 0, 0);
    board = '{16'd2, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2, 16'd0, 16'd1};
    run_check(4, 3, 0, 0);

    // Abort a check with reset after edge 10 of the run.
    board = '{16'd1, 16'd1, 16'd1, 16'd0, 16'd2, 16'd2, 16'd0, 16'd0, 16'd0};
    run_check(0, 0, 0, 0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_winner", winner, 0);
    chk("abort_draw", draw, 0);
    chk("abort_error", error, 0);
    chk("abort_addr", read_address, 8'h00);
    reset = 1'b0;
    dn = 0;
    repeat (25) begin
      @(posedge clock); #1;
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    run_check(0, 0, 0, 0);

    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 9; i++) begin
        r = int'($urandom_range(0, 19));
        board[i] = (r < 6) ? 16'd0 : (r < 12) ? 16'd1 : (r < 18) ? 16'd2 :
                   (r == 18) ? 16'h0003 : 16'h0101;
      end
      run_check(int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
